// File: rtl/multi_edge_detect.sv
// Multi-channel edge detector for asynchronous level inputs.
// Each channel runs raw input -> synchroniser -> debounce filter -> edge pulses,
// then qualifies the pulses by a per-channel mode into sticky pending/overrun flags.
// irq is the OR of all pending flags.
module multi_edge_detect #(
  parameter int CH          = 4,
  parameter int SYNC_STAGES = 2,
  parameter int DEBOUNCE    = 0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [CH-1:0]   in,
  input  logic [2*CH-1:0] mode,
  input  logic [CH-1:0]   clr,
  output logic [CH-1:0]   level_out,
  output logic [CH-1:0]   rise_out,
  output logic [CH-1:0]   fall_out,
  output logic [CH-1:0]   event_out,
  output logic [CH-1:0]   pending,
  output logic [CH-1:0]   overrun,
  output logic            irq
);

  // DEBOUNCE of 0 and 1 both mean "flip on the first differing sample".
  localparam int DB_MAX = (DEBOUNCE < 1) ? 1 : DEBOUNCE;
  localparam int CW_RAW = $clog2(DEBOUNCE + 1);
  localparam int CW     = (CW_RAW < 1) ? 1 : CW_RAW;
  // Counter value at which the next differing sample is the flipping one.
  localparam logic [CW-1:0] CNT_LAST = CW'(DB_MAX - 1);

  // Stage 0 takes the raw pins; stage SYNC_STAGES-1 is the synchronised value.
  logic [SYNC_STAGES-1:0][CH-1:0] sync_q;
  logic [CH-1:0]                  sync;

  assign sync = sync_q[SYNC_STAGES-1];

  // Synchroniser shift chain for all channels at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], in};
    end
  end

  for (genvar i = 0; i < CH; i++) begin : g_ch
    logic [CW-1:0] cnt_q;
    logic          lvl_q;
    logic          rise_q;
    logic          fall_q;

    // Debounce: count consecutive samples that disagree with the filtered
    // level; flip the level and emit the matching pulse on the last one.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        cnt_q  <= '0;
        lvl_q  <= 1'b0;
        rise_q <= 1'b0;
        fall_q <= 1'b0;
      end else if (sync[i] != lvl_q) begin
        if (cnt_q == CNT_LAST) begin
          cnt_q  <= '0;
          lvl_q  <= sync[i];
          rise_q <= sync[i];
          fall_q <= ~sync[i];
        end else begin
          cnt_q  <= cnt_q + 1'b1;
          rise_q <= 1'b0;
          fall_q <= 1'b0;
        end
      end else begin
        cnt_q  <= '0;
        rise_q <= 1'b0;
        fall_q <= 1'b0;
      end
    end

    assign level_out[i] = lvl_q;
    assign rise_out[i]  = rise_q;
    assign fall_out[i]  = fall_q;
    // Mode bit 0 enables rising events, bit 1 enables falling events.
    assign event_out[i] = (rise_q & mode[2*i]) | (fall_q & mode[2*i+1]);
  end

  // Sticky flags: an event sets pending (beating a same-cycle clear); an event
  // landing on an already-pending channel sets overrun; clr drops both.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending <= '0;
      overrun <= '0;
    end else begin
      pending <= event_out | (pending & ~clr);
      overrun <= (event_out & pending) | (overrun & ~clr);
    end
  end

  assign irq = |pending;

endmodule

// File: tb/tb_multi_edge_detect.sv
// Bench for multi_edge_detect: two instances share the same stimulus, one
// with no debounce and one with DEBOUNCE=4, both checked every cycle against
// a sample-history model plus directed literal checks.
module tb_multi_edge_detect;

  localparam int CH = 4;
  localparam int S  = 2;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [CH-1:0]   in_r   = '0;
  logic [2*CH-1:0] mode_r = 8'h55;
  logic [CH-1:0]   clr_r  = '0;

  logic [CH-1:0] lvl[2];
  logic [CH-1:0] rise[2];
  logic [CH-1:0] fall[2];
  logic [CH-1:0] evt[2];
  logic [CH-1:0] pend[2];
  logic [CH-1:0] ovr[2];
  logic          irq[2];

  multi_edge_detect #(.CH(CH), .SYNC_STAGES(S), .DEBOUNCE(0)) dut0 (
    .clk(clk), .rst(rst), .in(in_r), .mode(mode_r), .clr(clr_r),
    .level_out(lvl[0]), .rise_out(rise[0]), .fall_out(fall[0]),
    .event_out(evt[0]), .pending(pend[0]), .overrun(ovr[0]), .irq(irq[0])
  );

  multi_edge_detect #(.CH(CH), .SYNC_STAGES(S), .DEBOUNCE(4)) dut1 (
    .clk(clk), .rst(rst), .in(in_r), .mode(mode_r), .clr(clr_r),
    .level_out(lvl[1]), .rise_out(rise[1]), .fall_out(fall[1]),
    .event_out(evt[1]), .pending(pend[1]), .overrun(ovr[1]), .irq(irq[1])
  );

  int tests = 0;
  int fails = 0;

  // ---------------- reference model ----------------
  // Required consecutive agreeing samples per instance.
  int dm[2] = '{1, 4};
  // Raw samples in flight through the synchroniser (oldest first).
  logic [CH-1:0] pipe_q[$];
  // Synchronised samples seen by the filter, newest last.
  logic [CH-1:0] seen_q[$];
  logic [CH-1:0] m_lvl[2];
  logic [CH-1:0] m_rise[2];
  logic [CH-1:0] m_fall[2];
  logic [CH-1:0] m_pend[2];
  logic [CH-1:0] m_ovr[2];

  function automatic logic [CH-1:0] exp_event(int k);
    logic [CH-1:0] ev;
    for (int c = 0; c < CH; c++)
      ev[c] = (m_rise[k][c] & mode_r[2*c]) | (m_fall[k][c] & mode_r[2*c+1]);
    return ev;
  endfunction

  task automatic model_reset();
    pipe_q = {};
    for (int j = 0; j < S; j++) pipe_q.push_back('0);
    seen_q = {};
    for (int k = 0; k < 2; k++) begin
      m_lvl[k] = '0; m_rise[k] = '0; m_fall[k] = '0;
      m_pend[k] = '0; m_ovr[k] = '0;
    end
  endtask

  task automatic model_step();
    logic [CH-1:0] s;
    logic [CH-1:0] ev;
    logic          all_diff;
    s = pipe_q.pop_front();
    pipe_q.push_back(in_r);
    seen_q.push_back(s);
    if (seen_q.size() > 4) void'(seen_q.pop_front());
    for (int k = 0; k < 2; k++) begin
      ev = exp_event(k);
      for (int c = 0; c < CH; c++) begin
        if (ev[c]) begin
          if (m_pend[k][c]) m_ovr[k][c] = 1'b1;
          m_pend[k][c] = 1'b1;
        end else if (clr_r[c]) begin
          m_pend[k][c] = 1'b0;
          m_ovr[k][c]  = 1'b0;
        end
        // The level flips when the last dm samples all disagree with it.
        all_diff = (seen_q.size() >= dm[k]);
        for (int j = 0; j < dm[k] && all_diff; j++)
          if (seen_q[seen_q.size()-1-j][c] == m_lvl[k][c]) all_diff = 1'b0;
        m_rise[k][c] = all_diff & ~m_lvl[k][c];
        m_fall[k][c] = all_diff & m_lvl[k][c];
        if (all_diff) m_lvl[k][c] = ~m_lvl[k][c];
      end
    end
  endtask

  // ---------------- scoreboard ----------------
  task automatic check(string name, int k, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      if (fails <= 40)
        $display("FAIL %s inst%0d got %h expected %h at %0t", name, k, act, exp, $time);
    end
  endtask

  always @(posedge rst) model_reset();

  // Advance the model on each edge, then compare all outputs just after it.
  always @(posedge clk) begin
    if (rst) model_reset();
    else model_step();
    #1;
    for (int k = 0; k < 2; k++) begin
      check("level", k, 32'(lvl[k]),  32'(m_lvl[k]));
      check("rise",  k, 32'(rise[k]), 32'(m_rise[k]));
      check("fall",  k, 32'(fall[k]), 32'(m_fall[k]));
      check("event", k, 32'(evt[k]),  32'(exp_event(k)));
      check("pend",  k, 32'(pend[k]), 32'(m_pend[k]));
      check("ovr",   k, 32'(ovr[k]),  32'(m_ovr[k]));
      check("irq",   k, 32'(irq[k]),  32'(|m_pend[k]));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic cyc(int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic clear_all();
    clr_r = '1;
    cyc(1);
    clr_r = '0;
  endtask

  // ---------------- directed + random stimulus ----------------
  initial begin
    model_reset();
    cyc(3);
    rst = 1'b0;
    cyc(2);
    check("reset_level", 0, 32'(lvl[0]), 0);
    check("reset_pend",  1, 32'(pend[1]), 0);
    check("reset_irq",   0, 32'(irq[0]), 0);

    // Rising edge on ch0, no debounce: pulse after edge 2, pending after edge 3.
    in_r[0] = 1'b1;
    cyc(2);
    check("t1_rise_early", 0, 32'(rise[0]), 0);
    cyc(1);
    check("t1_rise", 0, 32'(rise[0]), 32'h1);
    check("t1_evt",  0, 32'(evt[0]),  32'h1);
    check("t1_lvl",  0, 32'(lvl[0]),  32'h1);
    check("t1_pend_early", 0, 32'(pend[0]), 0);
    cyc(1);
    check("t1_rise_gone", 0, 32'(rise[0]), 0);
    check("t1_pend", 0, 32'(pend[0]), 32'h1);
    check("t1_irq",  0, 32'(irq[0]), 1);
    // Debounced instance flips on edge 5.
    cyc(2);
    check("t1_db_rise", 1, 32'(rise[1]), 32'h1);
    cyc(1);
    check("t1_db_rise_gone", 1, 32'(rise[1]), 0);
    check("t1_db_lvl", 1, 32'(lvl[1]), 32'h1);

    // Short pulse on ch1 is rejected by DEBOUNCE=4.
    in_r[1] = 1'b1;
    cyc(3);
    in_r[1] = 1'b0;
    cyc(8);
    check("t2_glitch_lvl", 1, 32'(lvl[1] & 4'h2), 0);
    in_r[1] = 1'b1;
    cyc(5);
    check("t2_rise_early", 1, 32'(rise[1] & 4'h2), 0);
    cyc(1);
    check("t2_rise", 1, 32'(rise[1] & 4'h2), 32'h2);
    cyc(1);
    check("t2_rise_gone", 1, 32'(rise[1] & 4'h2), 0);
    cyc(6);

    // Mode on ch2: fall-only, both, off.
    mode_r[5:4] = 2'b10;
    in_r[2] = 1'b1;
    cyc(3);
    check("t3_rise", 0, 32'(rise[0] & 4'h4), 32'h4);
    check("t3_evt_masked", 0, 32'(evt[0] & 4'h4), 0);
    cyc(1);
    check("t3_pend_masked", 0, 32'(pend[0] & 4'h4), 0);
    cyc(4);
    in_r[2] = 1'b0;
    cyc(3);
    check("t3_fall", 0, 32'(fall[0] & 4'h4), 32'h4);
    check("t3_evt_fall", 0, 32'(evt[0] & 4'h4), 32'h4);
    cyc(1);
    check("t3_pend_fall", 0, 32'(pend[0] & 4'h4), 32'h4);
    cyc(4);
    clear_all();
    mode_r[5:4] = 2'b11;
    in_r[2] = 1'b1;
    cyc(3);
    check("t3_both_rise", 0, 32'(evt[0] & 4'h4), 32'h4);
    cyc(5);
    clear_all();
    in_r[2] = 1'b0;
    cyc(3);
    check("t3_both_fall", 0, 32'(evt[0] & 4'h4), 32'h4);
    cyc(5);
    clear_all();
    mode_r[5:4] = 2'b00;
    in_r[2] = 1'b1;
    cyc(3);
    check("t3_off_rise", 0, 32'(rise[0] & 4'h4), 32'h4);
    check("t3_off_evt", 0, 32'(evt[0] & 4'h4), 0);
    cyc(1);
    check("t3_off_pend", 0, 32'(pend[0] & 4'h4), 0);
    cyc(8);

    // Clear and overrun on ch3.
    clear_all();
    in_r[3] = 1'b1;
    cyc(4);
    check("t4_pend", 0, 32'(pend[0] & 4'h8), 32'h8);
    in_r[3] = 1'b0;
    cyc(4);
    in_r[3] = 1'b1;
    cyc(3);
    check("t4_evt", 0, 32'(evt[0] & 4'h8), 32'h8);
    clr_r[3] = 1'b1;
    cyc(1);
    check("t4_pend_kept", 0, 32'(pend[0] & 4'h8), 32'h8);
    check("t4_ovr_set", 0, 32'(ovr[0] & 4'h8), 32'h8);
    cyc(1);
    clr_r[3] = 1'b0;
    check("t4_pend_clr", 0, 32'(pend[0]), 0);
    check("t4_ovr_clr", 0, 32'(ovr[0]), 0);
    check("t4_irq_clr", 0, 32'(irq[0]), 0);
    cyc(6);

    // Asynchronous reset mid-debounce, release with ch0 still high.
    in_r[0] = 1'b0;
    cyc(10);
    in_r[0] = 1'b1;
    cyc(3);
    #2 rst = 1'b1;
    #1;
    for (int k = 0; k < 2; k++) begin
      check("t5_lvl", k, 32'(lvl[k]), 0);
      check("t5_rise", k, 32'(rise[k]), 0);
      check("t5_pend", k, 32'(pend[k]), 0);
      check("t5_irq", k, 32'(irq[k]), 0);
    end
    cyc(2);
    rst = 1'b0;
    cyc(2);
    check("t5_no_rise", 0, 32'(rise[0] & 4'h1), 0);
    cyc(1);
    check("t5_rise", 0, 32'(rise[0] & 4'h1), 32'h1);
    cyc(2);
    check("t5_db_no_rise", 1, 32'(rise[1] & 4'h1), 0);
    cyc(1);
    check("t5_db_rise", 1, 32'(rise[1] & 4'h1), 32'h1);
    cyc(1);
    check("t5_db_rise_gone", 1, 32'(rise[1] & 4'h1), 0);
    cyc(8);

    // All channels toggle together, mode both.
    mode_r = 8'hFF;
    clear_all();
    in_r = ~in_r;
    cyc(3);
    check("t6_pulses", 0, 32'(rise[0] | fall[0]), 32'hF);
    check("t6_evt", 0, 32'(evt[0]), 32'hF);
    cyc(1);
    check("t6_pend", 0, 32'(pend[0]), 32'hF);
    check("t6_pulses_gone", 0, 32'(rise[0] | fall[0]), 0);
    check("t6_ovr", 0, 32'(ovr[0]), 0);
    cyc(6);

    // Random phase against the model.
    for (int n = 0; n < 3000; n++) begin
      @(negedge clk);
      for (int c = 0; c < CH; c++)
        if ($urandom_range(0, 5) == 0) in_r[c] = ~in_r[c];
      if ($urandom_range(0, 31) == 0) mode_r = 8'($urandom);
      clr_r = ($urandom_range(0, 7) == 0) ? 4'($urandom) : 4'h0;
      if ($urandom_range(0, 999) == 0) begin
        #2 rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
      end
    end
    cyc(4);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
